// File: rtl/tcu_drl_int_ctrl.sv
// Sequencing controller for the integer TCU multiply lane array.
// Accepts one tile request, streams operand beats through the external
// combinational multiply unit, registers each product and accumulates it
// per lane into 32-bit wrapping accumulators, then returns the result.
module tcu_drl_int_ctrl #(
  parameter int N              = 2,
  parameter int TCK            = 2 * N,
  parameter int STEPS_W        = 8,
  parameter int TCU_MAX_INPUTS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_fmt,
  input  logic [TCU_MAX_INPUTS-1:0] req_vld_mask,
  input  logic [STEPS_W-1:0]        req_steps,
  input  logic [TCK*32-1:0]         req_c,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [N*32-1:0]           op_a_row,
  input  logic [N*32-1:0]           op_b_col,
  output logic                      mul_valid,
  output logic [2:0]                mul_fmt,
  output logic [TCU_MAX_INPUTS-1:0] mul_vld_mask,
  output logic [N*32-1:0]           mul_a_row,
  output logic [N*32-1:0]           mul_b_col,
  input  logic [TCK*25-1:0]         mul_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [TCK*32-1:0]         rsp_acc,
  output logic                      rsp_err
);

  // Integer format identifiers of the multiply unit (top bit marks integer).
  localparam logic [3:0] TCU_I8_ID = 4'd9;
  localparam logic [3:0] TCU_U8_ID = 4'd10;
  localparam logic [3:0] TCU_I4_ID = 4'd11;
  localparam logic [3:0] TCU_U4_ID = 4'd12;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  // Request-time latches (stage p0) and registered product (stage p1).
  logic [2:0]                fmt_p0;
  logic [TCU_MAX_INPUTS-1:0] mask_p0;
  logic [STEPS_W-1:0]        steps_p0;
  logic [STEPS_W-1:0]        issued;
  logic [STEPS_W-1:0]        retired;
  logic [TCK*25-1:0]         prod_p1;
  logic                      vld_p1;
  logic signed [31:0]        acc [TCK];

  logic req_fire;
  logic op_fire;
  logic rsp_fire;
  logic fmt_ok;
  logic last_retire;

  // Unsigned formats arrive zero-extended, so sign extension suits all formats.
  function automatic logic signed [31:0] sext25(input logic [24:0] v);
    return {{7{v[24]}}, v};
  endfunction

  function automatic logic is_int_fmt(input logic [2:0] f);
    logic [3:0] id;
    id = {1'b1, f};
    return (id == TCU_I8_ID) || (id == TCU_U8_ID) ||
           (id == TCU_I4_ID) || (id == TCU_U4_ID);
  endfunction

  assign req_fire    = req_valid & req_ready;
  assign op_fire     = op_valid & op_ready;
  assign rsp_fire    = rsp_valid & rsp_ready;
  assign fmt_ok      = is_int_fmt(req_fmt);
  assign last_retire = vld_p1 && ((retired + STEPS_W'(1)) == steps_p0);

  assign mul_valid    = op_fire;
  assign mul_fmt      = fmt_p0;
  assign mul_vld_mask = mask_p0;
  assign mul_a_row    = op_a_row;
  assign mul_b_col    = op_b_col;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: empty or unsupported tiles skip straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if ((req_steps == '0) || !fmt_ok) state_nxt = DONE;
          else                              state_nxt = RUN;
        end
      end
      RUN:     if (last_retire) state_nxt = DONE;
      DONE:    if (rsp_fire)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; rsp_acc is only exposed while a response is pending.
  always_comb begin
    req_ready = (state == IDLE);
    op_ready  = (state == RUN) && (issued != steps_p0);
    rsp_valid = (state == DONE);
    rsp_acc   = '0;
    if (state == DONE) begin
      for (int i = 0; i < TCK; i++) rsp_acc[i*32 +: 32] = acc[i];
    end
  end

  // Control: beat counters, product valid and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued  <= '0;
      retired <= '0;
      vld_p1  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      vld_p1 <= op_fire;
      if (req_fire) begin
        issued  <= '0;
        retired <= '0;
        rsp_err <= !fmt_ok;
      end else begin
        if (op_fire) issued  <= issued + STEPS_W'(1);
        if (vld_p1)  retired <= retired + STEPS_W'(1);
        if (rsp_fire) rsp_err <= 1'b0;
      end
    end
  end

  // Datapath: tile latches, product register and wrapping accumulation.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      fmt_p0   <= req_fmt;
      mask_p0  <= req_vld_mask;
      steps_p0 <= req_steps;
    end
    if (op_fire) prod_p1 <= mul_result;
    for (int i = 0; i < TCK; i++) begin
      if (req_fire)    acc[i] <= req_c[i*32 +: 32];
      else if (vld_p1) acc[i] <= acc[i] + sext25(prod_p1[i*25 +: 25]);
    end
  end

endmodule
